// File: rtl/fetch_stage.sv
// fetch_stage
//   Instruction fetch stage with a single outstanding memory request and an
//   IF/ID pipeline register. A small FSM tracks whether a fetch is in flight
//   (FETCH), a fetched word is parked because the pipeline is stalled (HELD),
//   or an in-flight request has been made wrong-path by a redirect and its
//   data must be thrown away when it returns (DISCARD).
//
// Ports
//   clk            : clock, all state updates on the rising edge
//   reset          : asynchronous active-high reset
//   imem_address   : fetch address (pc, or the stale request address in DISCARD)
//   imem_read      : fetch request, held until imem_resp
//   imem_rdata     : fetched word, valid with imem_resp
//   imem_resp      : fetch completes this cycle
//   gen_bubble     : hazard unit asks IF/ID and PC to hold
//   squash_ID      : current IF/ID instruction is wrong-path (masks id_ir only)
//   flow_ID_EX     : downstream accepts IF/ID this cycle
//   pc_load_target : redirect fetch to pc_target
//   pc_target      : redirect address (bit 0 forced to zero)
//   IF_ID_ir       : registered IF/ID instruction
//   IF_ID_pc       : registered PC+2 of IF_ID_ir
//   IF_ID_valid    : IF_ID_ir is a real fetched instruction
//   id_ir          : instruction handed to ID/EX, zero when squashed
module fetch_stage #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic [15:0] imem_address,
   output logic        imem_read,
   input  logic [15:0] imem_rdata,
   input  logic        imem_resp,
   input  logic        gen_bubble,
   input  logic        squash_ID,
   input  logic        flow_ID_EX,
   input  logic        pc_load_target,
   input  logic [15:0] pc_target,
   output logic [15:0] IF_ID_ir,
   output logic [15:0] IF_ID_pc,
   output logic        IF_ID_valid,
   output logic [15:0] id_ir
);

   typedef enum logic [1:0] {
      FETCH   = 2'd0,
      HELD    = 2'd1,
      DISCARD = 2'd2
   } state_t;

   state_t      state, state_next;
   logic [15:0] pc, pc_next;
   logic [15:0] ir_next, ifpc_next;
   logic        valid_next;
   logic [15:0] buffer, buffer_next;
   logic [15:0] req_addr, req_next;
   logic [15:0] pc_inc;
   logic        advance;

   assign advance = flow_ID_EX & ~gen_bubble;
   // 16-bit modulo increment: 16'hFFFE wraps to 16'h0000
   assign pc_inc  = pc + 16'd2;

   // A wrong-path request keeps its original address on the bus until the
   // memory answers, so the address never changes under an outstanding read.
   assign imem_read    = (state == FETCH) || (state == DISCARD);
   assign imem_address = (state == DISCARD) ? req_addr : pc;

   assign id_ir = squash_ID ? 16'h0000 : IF_ID_ir;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= FETCH;
         pc          <= RESET_PC;
         IF_ID_ir    <= 16'h0000;
         IF_ID_pc    <= 16'h0000;
         IF_ID_valid <= 1'b0;
         buffer      <= 16'h0000;
         req_addr    <= 16'h0000;
      end else begin
         state       <= state_next;
         pc          <= pc_next;
         IF_ID_ir    <= ir_next;
         IF_ID_pc    <= ifpc_next;
         IF_ID_valid <= valid_next;
         buffer      <= buffer_next;
         req_addr    <= req_next;
      end
   end

   always_comb begin
      state_next  = state;
      pc_next     = pc;
      ir_next     = IF_ID_ir;
      ifpc_next   = IF_ID_pc;
      valid_next  = IF_ID_valid;
      buffer_next = buffer;
      req_next    = req_addr;

      if (pc_load_target) begin
         // Redirect wins over advance and ignores flow_ID_EX; IF/ID becomes a
         // NOP so the wrong-path word never reaches decode.
         pc_next    = {pc_target[15:1], 1'b0};
         ir_next    = 16'h0000;
         valid_next = 1'b0;
         case (state)
            FETCH: begin
               if (imem_resp) begin
                  state_next = FETCH;
               end else begin
                  req_next   = pc;
                  state_next = DISCARD;
               end
            end
            HELD:    state_next = FETCH;
            DISCARD: state_next = imem_resp ? FETCH : DISCARD;
            default: state_next = FETCH;
         endcase
      end else begin
         case (state)
            FETCH: begin
               if (imem_resp && advance) begin
                  ir_next    = imem_rdata;
                  ifpc_next  = pc_inc;
                  valid_next = 1'b1;
                  pc_next    = pc_inc;
               end else if (imem_resp) begin
                  buffer_next = imem_rdata;
                  state_next  = HELD;
               end else if (advance) begin
                  // Nothing new to hand over: insert a bubble rather than
                  // letting decode see the same instruction twice.
                  ir_next    = 16'h0000;
                  valid_next = 1'b0;
               end
            end
            HELD: begin
               if (advance) begin
                  ir_next    = buffer;
                  ifpc_next  = pc_inc;
                  valid_next = 1'b1;
                  pc_next    = pc_inc;
                  state_next = FETCH;
               end
            end
            DISCARD: begin
               if (advance) begin
                  ir_next    = 16'h0000;
                  valid_next = 1'b0;
               end
               if (imem_resp) begin
                  state_next = FETCH;
               end
            end
            default: state_next = FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage: straight-line fetch, stall/HELD,
// bubble insertion, redirect during an outstanding request, squash masking,
// PC wrap, and asynchronous reset in the middle of a request.
module tb_fetch_stage;

   logic        clk;
   logic        reset;
   logic [15:0] imem_address;
   logic        imem_read;
   logic [15:0] imem_rdata;
   logic        imem_resp;
   logic        gen_bubble;
   logic        squash_ID;
   logic        flow_ID_EX;
   logic        pc_load_target;
   logic [15:0] pc_target;
   logic [15:0] IF_ID_ir;
   logic [15:0] IF_ID_pc;
   logic        IF_ID_valid;
   logic [15:0] id_ir;

   int checks;
   int failures;

   fetch_stage #(.RESET_PC(16'h0000)) dut (
      .clk            (clk),
      .reset          (reset),
      .imem_address   (imem_address),
      .imem_read      (imem_read),
      .imem_rdata     (imem_rdata),
      .imem_resp      (imem_resp),
      .gen_bubble     (gen_bubble),
      .squash_ID      (squash_ID),
      .flow_ID_EX     (flow_ID_EX),
      .pc_load_target (pc_load_target),
      .pc_target      (pc_target),
      .IF_ID_ir       (IF_ID_ir),
      .IF_ID_pc       (IF_ID_pc),
      .IF_ID_valid    (IF_ID_valid),
      .id_ir          (id_ir)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks         = 0;
      failures       = 0;
      reset          = 1'b1;
      imem_rdata     = 16'h0000;
      imem_resp      = 1'b0;
      gen_bubble     = 1'b0;
      squash_ID      = 1'b0;
      flow_ID_EX     = 1'b0;
      pc_load_target = 1'b0;
      pc_target      = 16'h0000;

      // Reset state
      #1;
      chk("rst_addr",  imem_address, 16'h0000);
      chk("rst_read",  {15'd0, imem_read}, 16'd1);
      chk("rst_ir",    IF_ID_ir, 16'h0000);
      chk("rst_ifpc",  IF_ID_pc, 16'h0000);
      chk("rst_valid", {15'd0, IF_ID_valid}, 16'd0);
      chk("rst_idir",  id_ir, 16'h0000);
      #8;
      reset = 1'b0;
      #1;
      chk("rel_read", {15'd0, imem_read}, 16'd1);
      chk("rel_addr", imem_address, 16'h0000);

      // Straight line A,B,C from 0x0000
      flow_ID_EX = 1'b1;
      imem_resp  = 1'b1;
      imem_rdata = 16'hA0A0;
      tick();
      chk("sl_ir_a",  IF_ID_ir, 16'hA0A0);
      chk("sl_pc_a",  IF_ID_pc, 16'h0002);
      chk("sl_v_a",   {15'd0, IF_ID_valid}, 16'd1);
      chk("sl_addr_a", imem_address, 16'h0002);
      imem_rdata = 16'hB0B0;
      tick();
      chk("sl_ir_b",  IF_ID_ir, 16'hB0B0);
      chk("sl_pc_b",  IF_ID_pc, 16'h0004);
      imem_rdata = 16'hC0C0;
      tick();
      chk("sl_ir_c",  IF_ID_ir, 16'hC0C0);
      chk("sl_pc_c",  IF_ID_pc, 16'h0006);
      chk("sl_addr_c", imem_address, 16'h0006);

      // Stall: response arrives under a bubble, word parked in HELD
      gen_bubble = 1'b1;
      imem_rdata = 16'h1234;
      tick();
      chk("st_read0", {15'd0, imem_read}, 16'd0);
      chk("st_ir0",   IF_ID_ir, 16'hC0C0);
      imem_resp  = 1'b0;
      imem_rdata = 16'hFFFF;
      tick();
      tick();
      chk("st_read2", {15'd0, imem_read}, 16'd0);
      chk("st_ir2",   IF_ID_ir, 16'hC0C0);
      chk("st_pc2",   IF_ID_pc, 16'h0006);
      gen_bubble = 1'b0;
      tick();
      chk("st_ir_rel",  IF_ID_ir, 16'h1234);
      chk("st_pc_rel",  IF_ID_pc, 16'h0008);
      chk("st_v_rel",   {15'd0, IF_ID_valid}, 16'd1);
      chk("st_addr_rel", imem_address, 16'h0008);
      chk("st_read_rel", {15'd0, imem_read}, 16'd1);

      // Advance with no response inserts a NOP, IF_ID_pc kept
      tick();
      chk("nop_ir", IF_ID_ir, 16'h0000);
      chk("nop_v",  {15'd0, IF_ID_valid}, 16'd0);
      chk("nop_pc", IF_ID_pc, 16'h0008);
      chk("nop_addr", imem_address, 16'h0008);

      // Walk pc up to 0x0010
      imem_resp = 1'b1;
      for (int i = 0; i < 4; i++) begin
         imem_rdata = 16'h2000 + 16'(i);
         tick();
      end
      chk("walk_ir", IF_ID_ir, 16'h2003);
      chk("walk_pc", IF_ID_pc, 16'h0010);

      // Redirect with the request to 0x0010 outstanding
      imem_resp      = 1'b0;
      flow_ID_EX     = 1'b0;
      pc_load_target = 1'b1;
      pc_target      = 16'h0041;
      tick();
      pc_load_target = 1'b0;
      chk("rd_addr0", imem_address, 16'h0010);
      chk("rd_read0", {15'd0, imem_read}, 16'd1);
      chk("rd_v0",    {15'd0, IF_ID_valid}, 16'd0);
      chk("rd_ir0",   IF_ID_ir, 16'h0000);
      tick();
      chk("rd_addr1", imem_address, 16'h0010);
      imem_resp  = 1'b1;
      imem_rdata = 16'hDEAD;
      flow_ID_EX = 1'b1;
      tick();
      chk("rd_addr2", imem_address, 16'h0040);
      chk("rd_ir2",   IF_ID_ir, 16'h0000);
      chk("rd_v2",    {15'd0, IF_ID_valid}, 16'd0);

      // Squash masks id_ir only
      imem_rdata = 16'h1283;
      tick();
      chk("sq_ir_load", IF_ID_ir, 16'h1283);
      chk("sq_pc_load", IF_ID_pc, 16'h0042);
      imem_resp  = 1'b0;
      flow_ID_EX = 1'b0;
      squash_ID  = 1'b1;
      #1;
      chk("sq_idir", id_ir, 16'h0000);
      chk("sq_ir",   IF_ID_ir, 16'h1283);
      tick();
      chk("sq_ir_hold", IF_ID_ir, 16'h1283);
      chk("sq_v_hold",  {15'd0, IF_ID_valid}, 16'd1);
      squash_ID = 1'b0;
      #1;
      chk("sq_idir_off", id_ir, 16'h1283);

      // Redirect with a simultaneous response: word dropped, fetch 0xFFFE
      imem_resp      = 1'b1;
      imem_rdata     = 16'hBEEF;
      flow_ID_EX     = 1'b1;
      pc_load_target = 1'b1;
      pc_target      = 16'hFFFF;
      tick();
      pc_load_target = 1'b0;
      chk("wr_addr0", imem_address, 16'hFFFE);
      chk("wr_read0", {15'd0, imem_read}, 16'd1);
      chk("wr_ir0",   IF_ID_ir, 16'h0000);

      // Wrap: fetch at 0xFFFE then advance
      imem_rdata = 16'h7777;
      tick();
      chk("wr_ir1",   IF_ID_ir, 16'h7777);
      chk("wr_pc1",   IF_ID_pc, 16'h0000);
      chk("wr_addr1", imem_address, 16'h0000);

      // Move fetch to 0x0100, leave it outstanding, then reset mid-cycle
      pc_load_target = 1'b1;
      pc_target      = 16'h0100;
      tick();
      pc_load_target = 1'b0;
      imem_resp      = 1'b0;
      chk("mr_addr", imem_address, 16'h0100);
      tick();
      #2;
      reset      = 1'b1;
      imem_resp  = 1'b1;
      imem_rdata = 16'hAAAA;
      #1;
      chk("ar_addr",  imem_address, 16'h0000);
      chk("ar_read",  {15'd0, imem_read}, 16'd1);
      chk("ar_ir",    IF_ID_ir, 16'h0000);
      chk("ar_ifpc",  IF_ID_pc, 16'h0000);
      chk("ar_valid", {15'd0, IF_ID_valid}, 16'd0);
      tick();
      chk("ar_ir_edge",   IF_ID_ir, 16'h0000);
      chk("ar_addr_edge", imem_address, 16'h0000);
      #3;
      reset     = 1'b0;
      imem_resp = 1'b0;
      #1;
      chk("pr_read", {15'd0, imem_read}, 16'd1);
      chk("pr_addr", imem_address, 16'h0000);
      imem_resp  = 1'b1;
      imem_rdata = 16'h5A5A;
      tick();
      chk("pr_ir",   IF_ID_ir, 16'h5A5A);
      chk("pr_ifpc", IF_ID_pc, 16'h0002);
      chk("pr_addr2", imem_address, 16'h0002);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, meaning the PC value loaded at reset.
REQ-002 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, meaning the reset; it is asynchronous and active-high.
REQ-004 SHALL have port imem_address, output, 16, meaning the instruction fetch address.
REQ-005 SHALL have port imem_read, output, 1, meaning a fetch request, held until imem_resp.
REQ-006 SHALL have port imem_rdata, input, 16, meaning the fetched word, valid when imem_resp=1.
REQ-007 SHALL have port imem_resp, input, 1, meaning the fetch completes this cycle.
REQ-008 SHALL have port gen_bubble, input, 1, meaning the hazard unit requests that IF/ID and PC hold.
REQ-009 SHALL have port squash_ID, input, 1, meaning the current IF/ID instruction is wrong-path.
REQ-010 SHALL have port flow_ID_EX, input, 1, meaning downstream accepts IF/ID this cycle.
REQ-011 SHALL have port pc_load_target, input, 1, meaning a redirect of fetch to pc_target.
REQ-012 SHALL have port pc_target, input, 16, meaning the redirect address.
REQ-013 SHALL have port IF_ID_ir, output, 16, meaning the registered IF/ID instruction.
REQ-014 SHALL have port IF_ID_pc, output, 16, meaning the registered PC+2 of IF_ID_ir.
REQ-015 SHALL have port IF_ID_valid, output, 1, meaning IF_ID_ir is a real fetched instruction.
REQ-016 SHALL have port id_ir, output, 16, meaning the instruction forwarded to ID/EX: 16'h0000 when squash_ID=1, else IF_ID_ir (combinational).

Function
REQ-017 SHALL define advance = flow_ID_EX & ~gen_bubble; IF/ID and PC change only on advance, except on redirect.
REQ-018 SHALL implement states FETCH, HELD and DISCARD.
REQ-019 FETCH: imem_read=1 and imem_address=pc; on imem_resp with advance, IF_ID <= {imem_rdata, pc+2, valid=1}, pc <= pc+2, stay FETCH.
REQ-020 FETCH: on imem_resp without advance, hold buffer <= imem_rdata, go HELD; pc unchanged.
REQ-021 FETCH: on advance without imem_resp, IF_ID <= {16'h0000, IF_ID_pc unchanged, valid=0} (NOP, so ID never sees a duplicate).
REQ-022 HELD: imem_read=0; on advance, IF_ID <= {buffer, pc+2, 1}, pc <= pc+2, go FETCH.
REQ-023 DISCARD: imem_read=1 with imem_address=req_addr (the address of the outstanding request); on imem_resp, drop imem_rdata and go FETCH.
REQ-024 Redirect (pc_load_target=1) SHALL take priority over advance and take effect regardless of flow_ID_EX: pc <= {pc_target[15:1],1'b0}; IF_ID <= NOP with valid=0.
REQ-025 Redirect in FETCH without imem_resp SHALL latch req_addr <= old pc and go DISCARD.
REQ-026 Redirect in FETCH with imem_resp, in HELD, or in DISCARD with imem_resp SHALL go FETCH and drop any fetched or buffered word.
REQ-027 Redirect in DISCARD without imem_resp SHALL stay DISCARD with req_addr unchanged.
REQ-028 imem_address and imem_read SHALL be stable while a request is outstanding.
REQ-029 PC arithmetic SHALL be 16-bit modulo; 16'hFFFE+2 = 16'h0000.
REQ-030 squash_ID SHALL NOT modify any register; it masks only id_ir.

Reset
REQ-031 On reset assertion, immediately: pc=RESET_PC, IF_ID_ir=16'h0000, IF_ID_pc=16'h0000, IF_ID_valid=0, buffer=0, req_addr=0, state=FETCH.
REQ-032 Reset SHALL abandon any outstanding request; the first request after release is to RESET_PC, and imem_read=1 in the first cycle after release.
REQ-033 imem_resp arriving in the same cycle reset is asserted SHALL be ignored.

Verification
REQ-034 Straight line: resp every cycle with words A,B,C from 0x0000 and advance=1 -> IF_ID_ir=A,B,C on consecutive cycles, IF_ID_pc=0x0002,0x0004,0x0006.
REQ-035 Stall: resp with 0x1234 while gen_bubble=1 for 3 cycles -> state HELD, imem_read=0, IF_ID unchanged; first advance -> IF_ID_ir=0x1234, pc +2.
REQ-036 Redirect mid-request: request to 0x0010 outstanding, pc_load_target=1 with pc_target=0x0041 -> imem_address stays 0x0010 until resp, data dropped, next request to 0x0040, IF_ID_valid=0.
REQ-037 Squash: IF_ID_ir=0x1283 with squash_ID=1 -> id_ir=0x0000 and IF_ID_ir still 0x1283.
REQ-038 Wrap and reset: pc=0xFFFE fetch then advance -> pc=0x0000; assert reset mid-request -> all outputs at reset values asynchronously, and the next request goes to RESET_PC.
